wb_sequencer: RTL and testbench
===============================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the register-file data width.
REQ-002 Parameter PC_WIDTH, default 8, is the program-counter width.
REQ-003 Parameter RA_WIDTH, default 5, is the register-address width.
REQ-004 Parameter MAX_LOADS, default 3, is the number of loads that may be outstanding.
REQ-005 Ports: clk in 1, the single clock; reset in 1, synchronous active-high; all logic on posedge clk.
REQ-006 ex_valid in 1, execute stage presents a writeback candidate; ex_sel in 2, source select (1? = link pc+4, 01 = load, 00 = ALU).
REQ-007 ex_rd in RA_WIDTH, destination; ex_pc in PC_WIDTH, signed pc; ex_alu_result in DATA_WIDTH.
REQ-008 mem_rsp_valid in 1, mem_rsp_rd in RA_WIDTH, mem_rsp_data in DATA_WIDTH: load response, always accepted.
REQ-009 ex_stall out 1, execute candidate not accepted this cycle.
REQ-010 rf_we out 1, rf_waddr out RA_WIDTH, rf_wdata out DATA_WIDTH: registered register-file write port.
REQ-011 loads_outstanding out 2, current count; rsp_error out 1, sticky protocol error.

Function
REQ-012 Accept = ex_valid && !ex_stall; accepted load (ex_sel=01) increments loads_outstanding and produces no write.
REQ-013 Accepted non-load with ex_rd!=0 yields a write: link data = (ex_pc+4) computed modulo 2^PC_WIDTH, sign-extended to DATA_WIDTH; ALU data = ex_alu_result.
REQ-014 Writes to rd=0 (execute or memory) are dropped, but load accounting still occurs.
REQ-015 mem_rsp_valid decrements loads_outstanding; if count is 0, count stays 0 and rsp_error sets.
REQ-016 Port priority per cycle: memory response > FIFO head > new execute write.
REQ-017 Execute writes are buffered in a 2-entry FIFO; a new execute write bypasses the FIFO only when the FIFO is empty and no memory response is present; otherwise it is pushed.
REQ-018 FIFO pushes and pops in the same cycle are allowed; order of execute writes is preserved.
REQ-019 ex_stall = FIFO full OR (ex_sel=01 AND loads_outstanding==MAX_LOADS AND no mem_rsp_valid this cycle); combinational from state and inputs.
REQ-020 ex_stall is asserted only when ex_valid is high; it is low otherwise.
REQ-021 Selected write appears on rf_we/rf_waddr/rf_wdata exactly one cycle after selection; rf_we=0 when nothing is selected.
REQ-022 Load increment and response decrement in the same cycle leave the count unchanged.

Reset
REQ-023 On reset, rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, loads_outstanding=0, rsp_error=0, ex_stall=0.
REQ-024 Reset mid-operation discards buffered writes and outstanding-load state; late responses then set rsp_error.

Structure
REQ-025 The ex_sel encodings (SEL_ALU=00, SEL_MEM=01, link=1?) and the MAX_LOADS default belong in the shared package for use by the datapath select logic.
REQ-026 The 2-entry FIFO is a sub-module named wb_fifo (parameterised width, full/empty flags); the arbitration and counter remain in wb_sequencer.

Verification
REQ-027 ALU op rd=3, data 0x1234 with idle memory -> next cycle rf_we=1, waddr=3, wdata=0x1234.
REQ-028 Link op rd=1, ex_pc=8'hFC -> rf_wdata=0x00000000; link op with ex_pc=8'h7C -> rf_wdata=0xFFFFFF80.
REQ-029 Memory response rd=5 coincides with ALU write rd=6 -> rd=5 written first, rd=6 one cycle later, ex_stall=0.
REQ-030 Three consecutive cycles of memory responses with ALU writes -> FIFO fills, ex_stall=1 on the third ALU write, and all writes drain in order.
REQ-031 Three loads issued with no responses -> loads_outstanding=3, fourth load stalls; a response in the same cycle -> fourth load accepted, count stays 3.
REQ-032 Memory response with count 0 -> rsp_error=1 and held until reset; a write to rd=0 -> rf_we remains 0.

Source files
------------

// File: rtl/wb_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: execute source encodings,
// outstanding-load limit and the write-port source decode.
package wb_sequencer_pkg;

  // Execute source select encodings; any value with bit 1 set is a link op.
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  // Default number of loads that may be in flight at once.
  localparam int MAX_LOADS_DEFAULT = 3;

  // Which requester owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_FIFO,
    SRC_EX
  } wb_src_e;

  // Link ops are identified by the high select bit alone (1? encoding).
  function automatic logic sel_is_link(input logic [1:0] sel);
    return (sel & SEL_LINK) != 2'b00;
  endfunction

  function automatic logic sel_is_load(input logic [1:0] sel);
    return sel == SEL_MEM;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO holding execute writes that lost the write port.
module wb_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign head_data = mem_q[rd_ptr_q];

  // Next-state pointers, occupancy and storage; push/pop in one cycle is legal.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // Control state register; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: arbitrates load responses, buffered execute writes and
// new execute writes onto one registered register-file write port, and
// tracks outstanding loads.
module wb_sequencer
  import wb_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 8,
  parameter int RA_WIDTH   = 5,
  parameter int MAX_LOADS  = MAX_LOADS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [1:0]            ex_sel,
  input  logic [RA_WIDTH-1:0]   ex_rd,
  input  logic [PC_WIDTH-1:0]   ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic                  mem_rsp_valid,
  input  logic [RA_WIDTH-1:0]   mem_rsp_rd,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  ex_stall,
  output logic                  rf_we,
  output logic [RA_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [1:0]            loads_outstanding,
  output logic                  rsp_error
);

  localparam int         ENTRY_W = RA_WIDTH + DATA_WIDTH;
  localparam logic [1:0] MAX_CNT = 2'(MAX_LOADS);

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [PC_WIDTH-1:0]   link_pc;
  logic [DATA_WIDTH-1:0] ex_data;
  logic                  ex_is_load, ex_writes, accept, ex_write;
  logic                  load_inc, rsp_dec;
  wb_src_e               src;

  logic                  rf_we_q, rf_we_d;
  logic [RA_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  wb_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data({ex_rd, ex_data}),
    .pop      (fifo_pop),
    .head_data(fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A response in the same cycle frees a load slot, so it lifts the load stall.
  assign ex_is_load = sel_is_load(ex_sel);
  assign ex_stall   = ex_valid &&
                      (fifo_full || (ex_is_load && (cnt_q == MAX_CNT) && !mem_rsp_valid));
  assign accept     = ex_valid && !ex_stall;

  // Execute write data: link address wraps in PC width then sign-extends.
  always_comb begin
    link_pc   = ex_pc + PC_WIDTH'(4);
    ex_writes = sel_is_link(ex_sel) || (ex_sel == SEL_ALU);
    ex_write  = accept && ex_writes && (ex_rd != '0);
    if (sel_is_link(ex_sel)) begin
      ex_data = {{(DATA_WIDTH - PC_WIDTH){link_pc[PC_WIDTH-1]}}, link_pc};
    end else begin
      ex_data = ex_alu_result;
    end
  end

  // Port arbitration: memory response, then FIFO head, then execute bypass.
  always_comb begin
    src        = SRC_NONE;
    fifo_pop   = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (mem_rsp_valid) begin
      src = SRC_MEM;
    end else if (!fifo_empty) begin
      src      = SRC_FIFO;
      fifo_pop = 1'b1;
    end else if (ex_write) begin
      src = SRC_EX;
    end
    // Any execute write that did not take the port waits in the FIFO.
    fifo_push = ex_write && (src != SRC_EX);
    unique case (src)
      SRC_MEM: begin
        // Loads to r0 still consume the port slot but never write.
        if (mem_rsp_rd != '0) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = mem_rsp_rd;
          rf_wdata_d = mem_rsp_data;
        end
      end
      SRC_FIFO: begin
        rf_we_d                  = 1'b1;
        {rf_waddr_d, rf_wdata_d} = fifo_head;
      end
      SRC_EX: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = ex_rd;
        rf_wdata_d = ex_data;
      end
      default: ;
    endcase
  end

  // Outstanding-load count; a response with nothing in flight is a sticky error.
  always_comb begin
    load_inc = accept && ex_is_load;
    rsp_dec  = mem_rsp_valid && (cnt_q != 2'd0);
    err_d    = err_q || (mem_rsp_valid && (cnt_q == 2'd0));
    cnt_d    = cnt_q;
    if (load_inc && !rsp_dec) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!load_inc && rsp_dec) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Registered write port and load-tracking state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign rf_we             = rf_we_q;
  assign rf_waddr          = rf_waddr_q;
  assign rf_wdata          = rf_wdata_q;
  assign loads_outstanding = cnt_q;
  assign rsp_error         = err_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Randomised and directed bench for wb_sequencer against a queue-based model.
module tb_wb_sequencer;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [1:0]  ex_sel;
  logic [4:0]  ex_rd;
  logic [7:0]  ex_pc;
  logic [31:0] ex_alu_result;
  logic        mem_rsp_valid;
  logic [4:0]  mem_rsp_rd;
  logic [31:0] mem_rsp_data;
  logic        ex_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  loads_outstanding;
  logic        rsp_error;

  wb_sequencer #(
    .DATA_WIDTH(32),
    .PC_WIDTH  (8),
    .RA_WIDTH  (5),
    .MAX_LOADS (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_sel           (ex_sel),
    .ex_rd            (ex_rd),
    .ex_pc            (ex_pc),
    .ex_alu_result    (ex_alu_result),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_rd       (mem_rsp_rd),
    .mem_rsp_data     (mem_rsp_data),
    .ex_stall         (ex_stall),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .loads_outstanding(loads_outstanding),
    .rsp_error        (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending execute writes in arrival order, load count, error flag.
  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t         pend_q[$];
  int          m_cnt;
  bit          m_err;
  bit          e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid      = 1'b0;
    ex_sel        = 2'b00;
    ex_rd         = 5'd0;
    ex_pc         = 8'd0;
    ex_alu_result = 32'd0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rd    = 5'd0;
    mem_rsp_data  = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    pend_q.delete();
    m_cnt  = 0;
    m_err  = 1'b0;
    e_we   = 1'b0;
    e_addr = 5'd0;
    e_data = 32'd0;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_cnt", loads_outstanding, 0);
    check("rst_err", rsp_error, 0);
    // After reset even a load request must not stall.
    ex_valid = 1'b1;
    ex_sel   = 2'b01;
    #1;
    check("rst_stall", ex_stall, 0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    $display("txn reset");
  endtask

  // One clock of stimulus, compared against the model before and after the edge.
  task automatic step(input bit v, input logic [1:0] sel, input logic [4:0] rd,
                      input logic [7:0] pc, input logic [31:0] alu,
                      input bit rv, input logic [4:0] rrd, input logic [31:0] rdat);
    bit          m_stall, acc, is_load, wr, was_empty;
    logic [7:0]  lp;
    int          sv;
    logic [31:0] xd;
    wr_t         w;
    @(negedge clk);
    ex_valid      = v;
    ex_sel        = sel;
    ex_rd         = rd;
    ex_pc         = pc;
    ex_alu_result = alu;
    mem_rsp_valid = rv;
    mem_rsp_rd    = rrd;
    mem_rsp_data  = rdat;
    #1;
    is_load = (sel == 2'b01);
    m_stall = v && ((pend_q.size() == 2) || (is_load && m_cnt == 3 && !rv));
    check("ex_stall", ex_stall, m_stall);
    acc = v && !m_stall;
    wr  = acc && !is_load && (rd != 5'd0);
    lp  = pc + 8'd4;
    sv  = int'(lp);
    if (sv >= 128) sv = sv - 256;
    xd  = sel[1] ? 32'(sv) : alu;
    was_empty = (pend_q.size() == 0);
    e_we = 1'b0;
    if (rv) begin
      if (rrd != 5'd0) begin
        e_we   = 1'b1;
        e_addr = rrd;
        e_data = rdat;
      end
      if (m_cnt == 0) m_err = 1'b1;
      else m_cnt = m_cnt - 1;
    end else if (!was_empty) begin
      w      = pend_q.pop_front();
      e_we   = 1'b1;
      e_addr = w.addr;
      e_data = w.data;
    end
    if (wr) begin
      if (!rv && was_empty) begin
        e_we   = 1'b1;
        e_addr = rd;
        e_data = xd;
      end else begin
        pend_q.push_back('{addr: rd, data: xd});
      end
    end
    if (acc && is_load) m_cnt = m_cnt + 1;
    @(posedge clk);
    #1;
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_waddr", rf_waddr, e_addr);
      check("rf_wdata", rf_wdata, e_data);
    end
    check("loads_outstanding", loads_outstanding, m_cnt);
    check("rsp_error", rsp_error, m_err);
    $display("txn v=%0b sel=%0d rd=%0d rsp=%0b rrd=%0d stall=%0b we=%0b waddr=%0d wdata=%08h cnt=%0d err=%0b",
             v, sel, rd, rv, rrd, ex_stall, rf_we, rf_waddr, rf_wdata, loads_outstanding, rsp_error);
  endtask

  task automatic idle_step();
    step(1'b0, 2'b00, 5'd0, 8'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // ALU write with idle memory appears one cycle later
    step(1'b1, 2'b00, 5'd3, 8'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    check("alu_we", rf_we, 1);
    check("alu_waddr", rf_waddr, 3);
    check("alu_wdata", rf_wdata, 32'h1234);

    // Link wrap and sign extension
    step(1'b1, 2'b10, 5'd1, 8'hFC, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    check("link_wrap", rf_wdata, 32'h0000_0000);
    step(1'b1, 2'b11, 5'd1, 8'h7C, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    check("link_sext", rf_wdata, 32'hFFFF_FF80);

    // Response and ALU write collide: response first, ALU next cycle
    do_reset();
    step(1'b1, 2'b01, 5'd5, 8'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 2'b00, 5'd6, 8'd0, 32'h66, 1'b1, 5'd5, 32'h55);
    check("coll_first", rf_waddr, 5);
    idle_step();
    check("coll_second", rf_waddr, 6);
    check("coll_second_data", rf_wdata, 32'h66);

    // Three response+ALU cycles fill the FIFO, then drain in order
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 5'd20 + 5'(i), 8'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 2'b00, 5'd10, 8'd0, 32'hA0, 1'b1, 5'd20, 32'hB0);
    check("fill_w1", rf_waddr, 20);
    step(1'b1, 2'b00, 5'd11, 8'd0, 32'hA1, 1'b1, 5'd21, 32'hB1);
    check("fill_w2", rf_waddr, 21);
    step(1'b1, 2'b00, 5'd12, 8'd0, 32'hA2, 1'b1, 5'd22, 32'hB2);
    check("fill_w3", rf_waddr, 22);
    check("fill_stall", ex_stall, 1);
    step(1'b1, 2'b00, 5'd12, 8'd0, 32'hA2, 1'b0, 5'd0, 32'd0);
    check("drain_w1", rf_waddr, 10);
    step(1'b1, 2'b00, 5'd12, 8'd0, 32'hA2, 1'b0, 5'd0, 32'd0);
    check("drain_w2", rf_waddr, 11);
    idle_step();
    check("drain_w3", rf_waddr, 12);
    check("drain_w3_data", rf_wdata, 32'hA2);

    // Load limit, and a same-cycle response admitting the fourth load
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 5'd1 + 5'(i), 8'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("max_cnt", loads_outstanding, 3);
    step(1'b1, 2'b01, 5'd4, 8'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("max_stall", ex_stall, 1);
    step(1'b1, 2'b01, 5'd4, 8'd0, 32'd0, 1'b1, 5'd7, 32'h77);
    check("max_cnt_hold", loads_outstanding, 3);
    check("max_rsp_waddr", rf_waddr, 7);

    // Response with nothing outstanding; write to r0 dropped
    do_reset();
    step(1'b0, 2'b00, 5'd0, 8'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    check("err_set", rsp_error, 1);
    idle_step();
    idle_step();
    check("err_held", rsp_error, 1);
    step(1'b1, 2'b00, 5'd0, 8'd0, 32'h99, 1'b0, 5'd0, 32'd0);
    check("r0_drop", rf_we, 0);

    // Reset mid-operation discards buffered writes and load state
    do_reset();
    step(1'b1, 2'b01, 5'd2, 8'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 2'b00, 5'd9, 8'd0, 32'h9, 1'b1, 5'd2, 32'h2);
    step(1'b1, 2'b01, 5'd3, 8'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    do_reset();
    idle_step();
    check("mid_rst_no_drain", rf_we, 0);
    step(1'b0, 2'b00, 5'd0, 8'd0, 32'd0, 1'b1, 5'd3, 32'h3);
    check("mid_rst_late_err", rsp_error, 1);

    // Random traffic; responses only when the model has loads in flight
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit          rv;
      logic [1:0]  sel;
      if (n == 300) do_reset();
      rv  = (m_cnt > 0) && ($urandom_range(0, 9) < 4);
      sel = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 9) < 7), sel, 5'($urandom_range(0, 31)),
           8'($urandom), $urandom, rv, 5'($urandom_range(0, 31)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
